scanner_link_receiver: RTL and testbench
========================================

// Module: scanner_link_receiver
// PURPOSE
//  Downstream stage of the scanner serial link: samples the LSB-first bit stream (dataOut qualified by clkOut),
//  assembles 8-bit words, decodes commands (2 READY_TO_TRANSFER, 3 START_SCANNING, 4 BUFFER_FULL, 7 DATA_HDR)
//  and captures the data byte that follows DATA_HDR. Tracks its own receive-buffer fill and drives the scanner's
//  readyForTransferIn and localTransferInput handshake inputs.
// PARAMETERS
//  BUF_DEPTH    16  receive-buffer capacity in data bytes (power of 2, >=4)
//  HALF_LEVEL   BUF_DEPTH/2  fill level that raises xferCtrl = 2'b10 ("other buffer at 50%")
//  GAP_TIMEOUT  8   clk cycles with linkValid low mid-word before the partial word is discarded
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst          in   1  asynchronous, active-low reset
//  linkValid    in   1  bit strobe (scanner clkOut); linkData is sampled on clk edges where linkValid=1
//  linkData     in   1  serial bit (scanner dataOut), LSB first
//  dataAck      in   1  consumer removes one byte from the receive buffer (ignored when fill=0)
//  cmdValid     out  1  one-cycle pulse, cmdCode valid
//  cmdCode      out  8  last decoded command word
//  dataValid    out  1  one-cycle pulse, dataByte valid
//  dataByte     out  8  last received data byte
//  fillLevel    out  $clog2(BUF_DEPTH)+1  bytes held
//  readyForTransfer out 1  to scanner readyForTransferIn: 1 while fillLevel < BUF_DEPTH and FSM in CMD
//  xferCtrl     out  2  to scanner localTransferInput: 01 start scanning, 10 half-level reached, 00 otherwise
//  frameErr     out  1  one-cycle pulse on gap timeout, unknown command, or data byte into full buffer
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=CMD, bit counter=0, shift reg=0, fillLevel=0, all outputs 0 except
//    readyForTransfer=1 after first clk with rst=1 (0 during reset).
//  - Bit counter 3 bits; each linkValid cycle shifts linkData into bit[cnt]; cnt wraps 7->0 completing a word.
//  - Word completion -> outputs registered, visible the cycle after the 8th bit (latency 1 clk).
//  - FSM CMD: completed word w:
//      w=3 -> cmdValid, xferCtrl=01 for exactly 1 cycle;  w=2,4 -> cmdValid only;
//      w=7 -> cmdValid, go DATA;  any other w -> frameErr, stay CMD, cmdCode unchanged.
//  - FSM DATA: completed word -> dataValid, dataByte=w, fillLevel+1, back to CMD.
//      fillLevel==BUF_DEPTH at completion -> byte dropped, frameErr, fillLevel unchanged, back to CMD.
//  - Same-cycle dataAck and data-byte completion -> fillLevel unchanged (net 0). dataAck at 0 -> no-op.
//  - xferCtrl=10 pulses 1 cycle when fillLevel transitions HALF_LEVEL-1 -> HALF_LEVEL; 01 has priority if both.
//  - Gap counter runs while cnt!=0 and linkValid=0; reaching GAP_TIMEOUT -> cnt=0, shift cleared, FSM=CMD,
//    frameErr. linkValid high clears the gap counter. No timeout while cnt==0 (idle line).
//  - Reset asserted mid-word or mid-DATA: everything returns to reset state immediately; partial word lost.
// CONFIGURATION
//  LINK_RX_STATS_EN defined: adds outputs cmdCount[15:0], dataCount[15:0], errCount[7:0]; saturating counters,
//    incremented on cmdValid/dataValid/frameErr, cleared by reset only.
//  LINK_RX_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package scanner_link_pkg: command constants CMD_READY=8'd2, CMD_START=8'd3, CMD_FULL=8'd4,
//    CMD_DATA=8'd7; xferCtrl encodings XFER_NONE/XFER_START/XFER_HALF; FSM state enum {CMD, DATA}.
//  - Sub-module link_bit_deserializer: bit counter, shift register, gap timeout; outputs wordValid/word/gapErr.
//    Top level holds FSM, fill counter, handshake and optional stats.
// TESTING
//  1 Reset: rst=0 mid-word after 3 bits -> all outputs 0; release, send 8'd3 -> cmdValid, cmdCode=3, xferCtrl=01 1 cycle.
//  2 Data: send 7 then 8'hA5 LSB-first -> cmdValid(7), next word dataValid, dataByte=A5, fillLevel=1.
//  3 Half/full: 8 DATA frames -> xferCtrl=10 on 8th; 16 total -> readyForTransfer=0; 17th -> frameErr, fill=16.
//  4 Gap: 4 bits then linkValid low 8 cycles -> frameErr; then send 8'd2 -> cmdValid, cmdCode=2 (resynced).
//  5 Unknown cmd 8'd9 -> frameErr, no cmdValid; simultaneous dataAck+data byte at fill=5 -> fill stays 5.
//  6 LINK_RX_STATS_EN: tests 2-5 -> cmdCount/dataCount/errCount match pulse totals; compile without macro passes 1-5.

Source files
------------

// File: rtl/scanner_link_pkg.sv
// Purpose: shared constants, command codes and FSM state type for the scanner link receiver.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package scanner_link_pkg;

    localparam int WORD_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic [WORD_W-1:0] CMD_READY = 8'd2;
    localparam logic [WORD_W-1:0] CMD_START = 8'd3;
    localparam logic [WORD_W-1:0] CMD_FULL  = 8'd4;
    localparam logic [WORD_W-1:0] CMD_DATA  = 8'd7;

    localparam logic [1:0] XFER_NONE  = 2'b00;
    localparam logic [1:0] XFER_START = 2'b01;
    localparam logic [1:0] XFER_HALF  = 2'b10;

    typedef enum logic {
        CMD  = 1'b0,
        DATA = 1'b1
    } rx_state_e;

    // Any word outside this set is a protocol violation while waiting for a command.
    function automatic logic is_known_cmd(input logic [WORD_W-1:0] w);
        return (w == CMD_READY) || (w == CMD_START) || (w == CMD_FULL) || (w == CMD_DATA);
    endfunction

endpackage

// File: rtl/link_bit_deserializer.sv
// Purpose: LSB-first bit assembler with mid-word gap timeout; emits completed 8-bit words.
// Latency: combinational word_vld/word_dat in the cycle the 8th bit is strobed; gap_err on the timeout cycle.
// Backpressure: none; every strobed bit is accepted, the consumer must take each word when offered.
module link_bit_deserializer
    import scanner_link_pkg::*;
#(
    parameter int GAP_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_vld,
    input  logic              bit_dat,
    output logic              word_vld,
    output logic [WORD_W-1:0] word_dat,
    output logic              gap_err
);

    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]    shift_q, shift_d;
    logic [GAP_W-1:0]     gap_q, gap_d;

    // Next-state for bit position, shift register and gap counter; word and timeout strobes.
    always_comb begin
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        gap_d    = gap_q;
        word_vld = 1'b0;
        gap_err  = 1'b0;
        // Shift register with the incoming bit merged in at the current position.
        word_dat          = shift_q;
        word_dat[cnt_q]   = bit_dat;

        if (bit_vld) begin
            gap_d = '0;
            if (cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
                word_vld = 1'b1;
                cnt_d    = '0;
                shift_d  = '0;
            end else begin
                cnt_d   = cnt_q + BIT_CNT_W'(1);
                shift_d = word_dat;
            end
        end else if (cnt_q != '0) begin
            // Only a partially received word can time out; an idle line never does.
            if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                gap_err = 1'b1;
                cnt_d   = '0;
                shift_d = '0;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end
    end

    // Register deserializer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            gap_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: rtl/scanner_link_receiver.sv
// Purpose: scanner link receiver - command decode, data byte capture, buffer fill and scanner handshake.
// Latency: 1 clk from the 8th strobed bit to cmdValid/dataValid/frameErr and updated fill/handshake outputs.
// Backpressure: readyForTransfer drops when the buffer is full or a data byte is pending; bytes into a full buffer are dropped with frameErr.
// Optional: define LINK_RX_STATS_EN to add saturating cmdCount/dataCount/errCount outputs.
module scanner_link_receiver
    import scanner_link_pkg::*;
#(
    parameter int BUF_DEPTH   = 16,
    parameter int HALF_LEVEL  = BUF_DEPTH / 2,
    parameter int GAP_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       linkValid,
    input  logic                       linkData,
    input  logic                       dataAck,
    output logic                       cmdValid,
    output logic [7:0]                 cmdCode,
    output logic                       dataValid,
    output logic [7:0]                 dataByte,
    output logic [$clog2(BUF_DEPTH):0] fillLevel,
    output logic                       readyForTransfer,
    output logic [1:0]                 xferCtrl,
    output logic                       frameErr
`ifdef LINK_RX_STATS_EN
    ,
    output logic [15:0]                cmdCount,
    output logic [15:0]                dataCount,
    output logic [7:0]                 errCount
`endif
);

    localparam int FILL_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [FILL_W-1:0] FILL_FULL     = FILL_W'(BUF_DEPTH);
    localparam logic [FILL_W-1:0] FILL_HALF     = FILL_W'(HALF_LEVEL);
    localparam logic [FILL_W-1:0] FILL_HALF_M1  = FILL_W'(HALF_LEVEL - 1);

    logic              word_vld;
    logic [WORD_W-1:0] word_dat;
    logic              gap_err;

    link_bit_deserializer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_deser (
        .clk      (clk),
        .rst_n    (rst),
        .bit_vld  (linkValid),
        .bit_dat  (linkData),
        .word_vld (word_vld),
        .word_dat (word_dat),
        .gap_err  (gap_err)
    );

    rx_state_e         state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              cmd_vld_q, cmd_vld_d;
    logic [7:0]        cmd_code_q, cmd_code_d;
    logic              data_vld_q, data_vld_d;
    logic [7:0]        data_byte_q, data_byte_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        xfer_q, xfer_d;
    logic              rdy_q, rdy_d;
    logic              start_req;
    logic              byte_in;
    logic              byte_out;

    // Word decode, fill accounting and handshake generation for the next cycle.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        cmd_vld_d   = 1'b0;
        cmd_code_d  = cmd_code_q;
        data_vld_d  = 1'b0;
        data_byte_d = data_byte_q;
        frame_err_d = 1'b0;
        xfer_d      = XFER_NONE;
        start_req   = 1'b0;
        byte_in     = 1'b0;

        if (gap_err) begin
            // Partial word discarded; resynchronise on the command stream.
            state_d     = CMD;
            frame_err_d = 1'b1;
        end else if (word_vld) begin
            if (state_q == CMD) begin
                if (is_known_cmd(word_dat)) begin
                    cmd_vld_d  = 1'b1;
                    cmd_code_d = word_dat;
                    start_req  = (word_dat == CMD_START);
                    if (word_dat == CMD_DATA) begin
                        state_d = DATA;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                state_d = CMD;
                if (fill_q == FILL_FULL) begin
                    frame_err_d = 1'b1;
                end else begin
                    data_vld_d  = 1'b1;
                    data_byte_d = word_dat;
                    byte_in     = 1'b1;
                end
            end
        end

        // An ack on an empty buffer has nothing to remove.
        byte_out = dataAck && (fill_q != '0);
        case ({byte_in, byte_out})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase

        // Start request wins over the half-level notification if both land together.
        if (start_req) begin
            xfer_d = XFER_START;
        end else if ((fill_q == FILL_HALF_M1) && (fill_d == FILL_HALF)) begin
            xfer_d = XFER_HALF;
        end

        rdy_d = (state_d == CMD) && (fill_d < FILL_FULL);
    end

    // Receiver FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CMD;
            fill_q      <= '0;
            cmd_vld_q   <= 1'b0;
            cmd_code_q  <= '0;
            data_vld_q  <= 1'b0;
            data_byte_q <= '0;
            frame_err_q <= 1'b0;
            xfer_q      <= XFER_NONE;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_code_q  <= cmd_code_d;
            data_vld_q  <= data_vld_d;
            data_byte_q <= data_byte_d;
            frame_err_q <= frame_err_d;
            xfer_q      <= xfer_d;
            rdy_q       <= rdy_d;
        end
    end

    assign cmdValid         = cmd_vld_q;
    assign cmdCode          = cmd_code_q;
    assign dataValid        = data_vld_q;
    assign dataByte         = data_byte_q;
    assign fillLevel        = fill_q;
    assign readyForTransfer = rdy_q;
    assign xferCtrl         = xfer_q;
    assign frameErr         = frame_err_q;

`ifdef LINK_RX_STATS_EN
    logic [15:0] cmd_count_q, cmd_count_d;
    logic [15:0] data_count_q, data_count_d;
    logic [7:0]  err_count_q, err_count_d;

    // Saturating event counters fed by the registered output pulses.
    always_comb begin
        cmd_count_d  = cmd_count_q;
        data_count_d = data_count_q;
        err_count_d  = err_count_q;
        if (cmd_vld_q && (cmd_count_q != 16'hFFFF)) begin
            cmd_count_d = cmd_count_q + 16'd1;
        end
        if (data_vld_q && (data_count_q != 16'hFFFF)) begin
            data_count_d = data_count_q + 16'd1;
        end
        if (frame_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Counters clear only on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_count_q  <= '0;
            data_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            cmd_count_q  <= cmd_count_d;
            data_count_q <= data_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign cmdCount  = cmd_count_q;
    assign dataCount = data_count_q;
    assign errCount  = err_count_q;
`endif

endmodule

// File: tb/tb_scanner_link_receiver.sv
// Purpose: self-checking bench for scanner_link_receiver; table of words with expected events plus reset/gap sequences.
// Latency: expected events are queued as each word is driven and matched when the DUT pulses.
// Backpressure: each queued expectation must be consumed within a bounded number of cycles.
module tb_scanner_link_receiver;
    import scanner_link_pkg::*;

    localparam int K_CMD  = 0;
    localparam int K_DATA = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] code;   // cmdCode for CMD/ERR, dataByte for DATA
        logic [1:0] xfer;
        logic [4:0] fill;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic [7:0] w;
        logic       ack;
        int         pre_acks;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       linkValid = 1'b0;
    logic       linkData = 1'b0;
    logic       dataAck = 1'b0;
    logic       cmdValid;
    logic [7:0] cmdCode;
    logic       dataValid;
    logic [7:0] dataByte;
    logic [4:0] fillLevel;
    logic       readyForTransfer;
    logic [1:0] xferCtrl;
    logic       frameErr;
`ifdef LINK_RX_STATS_EN
    logic [15:0] cmdCount;
    logic [15:0] dataCount;
    logic [7:0]  errCount;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_cmd = 0;
    int   n_data = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    scanner_link_receiver dut (
        .clk              (clk),
        .rst              (rst),
        .linkValid        (linkValid),
        .linkData         (linkData),
        .dataAck          (dataAck),
        .cmdValid         (cmdValid),
        .cmdCode          (cmdCode),
        .dataValid        (dataValid),
        .dataByte         (dataByte),
        .fillLevel        (fillLevel),
        .readyForTransfer (readyForTransfer),
        .xferCtrl         (xferCtrl),
        .frameErr         (frameErr)
`ifdef LINK_RX_STATS_EN
        ,
        .cmdCount         (cmdCount),
        .dataCount        (dataCount),
        .errCount         (errCount)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] kind_bits(input int k);
        case (k)
            K_CMD:   return 3'b100;
            K_DATA:  return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic expect_ev(input int kind, input logic [7:0] code, input logic [1:0] xfer,
                             input logic [4:0] fill, input logic rdy);
        exp_t e;
        e.kind = kind; e.code = code; e.xfer = xfer; e.fill = fill; e.rdy = rdy;
        sb.push_back(e);
        if (kind == K_CMD) n_cmd++;
        else if (kind == K_DATA) n_data++;
        else n_err++;
    endtask

    task automatic add_vec(input logic [7:0] w, input logic ack, input int pre_acks, input int kind,
                           input logic [7:0] code, input logic [1:0] xfer, input logic [4:0] fill,
                           input logic rdy);
        vec_t v;
        v.w = w; v.ack = ack; v.pre_acks = pre_acks;
        v.e.kind = kind; v.e.code = code; v.e.xfer = xfer; v.e.fill = fill; v.e.rdy = rdy;
        vecs.push_back(v);
    endtask

    // Scoreboard: every output pulse must match the oldest expectation; xferCtrl may only be set on a pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (cmdValid || dataValid || frameErr)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got cmd=%0b data=%0b err=%0b, expected none",
                         cmdValid, dataValid, frameErr);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'({cmdValid, dataValid, frameErr}), 32'(kind_bits(e.kind)));
                if (e.kind == K_DATA) check("dataByte", 32'(dataByte), 32'(e.code));
                else check("cmdCode", 32'(cmdCode), 32'(e.code));
                check("xferCtrl", 32'(xferCtrl), 32'(e.xfer));
                check("fillLevel", 32'(fillLevel), 32'(e.fill));
                check("readyForTransfer", 32'(readyForTransfer), 32'(e.rdy));
            end
        end else if (rst && (xferCtrl != XFER_NONE)) begin
            checks++;
            errors++;
            $display("FAIL stray_xferCtrl: got %b, expected 00 outside a command/data pulse", xferCtrl);
        end
    end

    task automatic send_word(input logic [7:0] w, input logic ack);
        for (int i = 0; i < 8; i++) begin
            linkValid = 1'b1;
            linkData  = w[i];
            dataAck   = ack && (i == 7);
            @(posedge clk); #1;
        end
        linkValid = 1'b0;
        linkData  = 1'b0;
        dataAck   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_timeout: got %0d pending events, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Three bits of a word, then asynchronous reset between clock edges.
    task automatic reset_mid_word();
        for (int i = 0; i < 3; i++) begin
            linkValid = 1'b1;
            linkData  = 1'b1;
            @(posedge clk); #1;
        end
        linkValid = 1'b0;
        linkData  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset_outputs",
              32'({cmdValid, cmdCode, dataValid, dataByte, fillLevel, readyForTransfer, xferCtrl, frameErr}),
              32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(readyForTransfer), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        // Vector table: data frames up to full, overflow, commands, unknown command, simultaneous ack.
        for (int i = 1; i <= 16; i++) begin
            b = (i == 1) ? 8'hA5 : 8'(8'h40 + i);
            add_vec(CMD_DATA, 1'b0, 0, K_CMD, CMD_DATA, XFER_NONE, 5'(i - 1), 1'b0);
            add_vec(b, 1'b0, 0, K_DATA, b, (i == 8) ? XFER_HALF : XFER_NONE, 5'(i), (i < 16));
        end
        add_vec(CMD_DATA,  1'b0, 0,  K_CMD,  CMD_DATA,  XFER_NONE,  5'd16, 1'b0);
        add_vec(8'hEE,     1'b0, 0,  K_ERR,  CMD_DATA,  XFER_NONE,  5'd16, 1'b0);
        add_vec(CMD_READY, 1'b0, 0,  K_CMD,  CMD_READY, XFER_NONE,  5'd16, 1'b0);
        add_vec(CMD_FULL,  1'b0, 0,  K_CMD,  CMD_FULL,  XFER_NONE,  5'd16, 1'b0);
        add_vec(8'd9,      1'b0, 0,  K_ERR,  CMD_FULL,  XFER_NONE,  5'd16, 1'b0);
        add_vec(CMD_DATA,  1'b0, 11, K_CMD,  CMD_DATA,  XFER_NONE,  5'd5,  1'b0);
        add_vec(8'h3C,     1'b1, 0,  K_DATA, 8'h3C,     XFER_NONE,  5'd5,  1'b1);
        add_vec(CMD_START, 1'b0, 0,  K_CMD,  CMD_START, XFER_NONE | XFER_START, 5'd5, 1'b1);

        // Reset state, then reset released.
        #3;
        check("reset_outputs_initial",
              32'({cmdValid, cmdCode, dataValid, dataByte, fillLevel, readyForTransfer, xferCtrl, frameErr}),
              32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("ready_first_clk", 32'(readyForTransfer), 32'd1);

        // Reset mid-word loses the partial bits; a clean start command follows.
        reset_mid_word();
        expect_ev(K_CMD, CMD_START, XFER_START, 5'd0, 1'b1);
        send_word(CMD_START, 1'b0);
        wait_drain();

        // Ack on an empty buffer is a no-op.
        dataAck = 1'b1;
        @(posedge clk); #1;
        dataAck = 1'b0;
        @(posedge clk); #1;
        check("ack_at_empty", 32'(fillLevel), 32'd0);

        // Gap timeout after 4 bits, then resync on a ready command.
        expect_ev(K_ERR, CMD_START, XFER_NONE, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            linkValid = 1'b1;
            linkData  = 1'b1;
            @(posedge clk); #1;
        end
        linkValid = 1'b0;
        linkData  = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
        end
        wait_drain();
        expect_ev(K_CMD, CMD_READY, XFER_NONE, 5'd0, 1'b1);
        send_word(CMD_READY, 1'b0);
        wait_drain();

        // Table-driven section.
        foreach (vecs[i]) begin
            repeat (vecs[i].pre_acks) begin
                dataAck = 1'b1;
                @(posedge clk); #1;
            end
            dataAck = 1'b0;
            expect_ev(vecs[i].e.kind, vecs[i].e.code, vecs[i].e.xfer, vecs[i].e.fill, vecs[i].e.rdy);
            send_word(vecs[i].w, vecs[i].ack);
            wait_drain();
        end

`ifdef LINK_RX_STATS_EN
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("cmdCount", 32'(cmdCount), 32'(n_cmd));
        check("dataCount", 32'(dataCount), 32'(n_data));
        check("errCount", 32'(errCount), 32'(n_err));
`endif

        // Reset while waiting for a data byte: FSM returns to CMD with an empty buffer.
        expect_ev(K_CMD, CMD_DATA, XFER_NONE, 5'd5, 1'b0);
        send_word(CMD_DATA, 1'b0);
        wait_drain();
        reset_mid_word();
        expect_ev(K_CMD, CMD_START, XFER_START, 5'd0, 1'b1);
        send_word(CMD_START, 1'b0);
        wait_drain();

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
